// File: rtl/data_mem_unit.sv
// data_mem_unit
//   MEM-stage data memory for the 5-stage MIPS pipeline. It takes the M-stage
//   outputs of the EX/MEM register and does byte, halfword and word stores
//   into a word-organised RAM. It returns sign- or zero-extended load data
//   combinationally to the MEM/WB register. It also flags misaligned accesses
//   and counts performed loads and stores for debug.
//
// Ports
//   clk            pipeline clock, all state updates on the rising edge
//   rst            synchronous active-high reset (clears RAM, counters, sticky)
//   ALUOutM        byte address of the access
//   WriteDataM     right-aligned store data
//   MemWriteM      store request
//   MemToRegM      load request
//   IsLbSbM        byte-sized access (takes precedence over IsLhShM)
//   IsLhShM        halfword-sized access; word when neither size flag is set
//   IsUnsignedM    zero-extend loads when 1, sign-extend when 0
//   ReadDataM      extended load data (combinational, 0 when no valid load)
//   AlignErrM      current access is misaligned (combinational)
//   AlignErrSticky set on the edge after any misaligned access, cleared by rst
//   LoadCount      performed (aligned) loads, wraps
//   StoreCount     performed (aligned) stores, wraps
module data_mem_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic        MemToRegM,
  input  logic        IsLbSbM,
  input  logic        IsLhShM,
  input  logic        IsUnsignedM,
  output logic [31:0] ReadDataM,
  output logic        AlignErrM,
  output logic        AlignErrSticky,
  output logic [31:0] LoadCount,
  output logic [31:0] StoreCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            off;
  logic [31:0]           rd_word;
  logic                  misaligned;
  logic                  st_en;
  logic                  ld_en;
  logic [31:0]           store_cnt;
  logic [31:0]           load_cnt;
  logic                  err_sticky;

  // Upper address bits are deliberately ignored, so addresses alias.
  logic unused_addr;
  assign unused_addr = ^ALUOutM[31:ADDR_WIDTH+2];

  // Merge right-aligned store data into the selected lanes of the old word.
  function automatic logic [31:0] merge_store(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic [1:0]  boff,
    input logic        is_b,
    input logic        is_h
  );
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] res;
    if (is_b) begin
      be    = 4'b0001 << boff;
      lanes = {4{wdata[7:0]}};
    end else if (is_h) begin
      be    = boff[1] ? 4'b1100 : 4'b0011;
      lanes = {2{wdata[15:0]}};
    end else begin
      be    = 4'b1111;
      lanes = wdata;
    end
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? lanes[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  // Pick the byte/half at the offset and extend it to 32 bits.
  function automatic logic [31:0] extend_load(
    input logic [31:0] word,
    input logic [1:0]  boff,
    input logic        is_b,
    input logic        is_h,
    input logic        is_u
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{boff, 3'b000} +: 8];
    h = word[{boff[1], 4'b0000} +: 16];
    if (is_b) begin
      res = is_u ? {24'd0, b} : {{24{b[7]}}, b};
    end else if (is_h) begin
      res = is_u ? {16'd0, h} : {{16{h[15]}}, h};
    end else begin
      res = word;
    end
    return res;
  endfunction

  assign word_idx = ALUOutM[ADDR_WIDTH+1:2];
  assign off      = ALUOutM[1:0];
  assign rd_word  = mem[word_idx];

  always_comb begin
    misaligned = 1'b0;
    if (IsLbSbM) begin
      misaligned = 1'b0;
    end else if (IsLhShM) begin
      misaligned = off[0];
    end else begin
      misaligned = (off != 2'b00);
    end
  end

  // A simultaneous load+store request is treated as a store only.
  assign AlignErrM = (MemWriteM | MemToRegM) & misaligned;
  assign st_en     = MemWriteM & ~misaligned;
  assign ld_en     = MemToRegM & ~MemWriteM & ~misaligned;

  // ReadDataM shows pre-write contents even when a store is also requested.
  assign ReadDataM = (MemToRegM & ~misaligned)
                   ? extend_load(rd_word, off, IsLbSbM, IsLhShM, IsUnsignedM)
                   : 32'd0;

  // RAM: reset clears every word and takes priority over a coincident store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (st_en) begin
      mem[word_idx] <= merge_store(rd_word, WriteDataM, off, IsLbSbM, IsLhShM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_cnt  <= 32'd0;
      load_cnt   <= 32'd0;
      err_sticky <= 1'b0;
    end else begin
      if (st_en) store_cnt <= store_cnt + 32'd1;
      if (ld_en) load_cnt  <= load_cnt + 32'd1;
      if (AlignErrM) err_sticky <= 1'b1;
    end
  end

  assign StoreCount     = store_cnt;
  assign LoadCount      = load_cnt;
  assign AlignErrSticky = err_sticky;

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic        MemWriteM;
  logic        MemToRegM;
  logic        IsLbSbM;
  logic        IsLhShM;
  logic        IsUnsignedM;
  logic [31:0] ReadDataM;
  logic        AlignErrM;
  logic        AlignErrSticky;
  logic [31:0] LoadCount;
  logic [31:0] StoreCount;

  always #5 clk = ~clk;

  data_mem_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .IsLbSbM(IsLbSbM),
    .IsLhShM(IsLhShM), .IsUnsignedM(IsUnsignedM), .ReadDataM(ReadDataM),
    .AlignErrM(AlignErrM), .AlignErrSticky(AlignErrSticky),
    .LoadCount(LoadCount), .StoreCount(StoreCount)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        lb;
    logic        lh;
    logic        uns;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t  tbl [24];
  exp_t  sbq [$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] mdl_st = 0;
  logic [31:0] mdl_ld = 0;
  logic        mdl_sticky = 0;

  function automatic vec_t mk(string n, logic [31:0] a, logic [31:0] d,
                              logic we, logic re, logic lb, logic lh,
                              logic uns, logic [31:0] erd, logic eerr);
    vec_t v;
    v.name = n; v.addr = a; v.wdata = d; v.we = we; v.re = re;
    v.lb = lb; v.lh = lh; v.uns = uns; v.exp_rd = erd; v.exp_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    MemWriteM = 0; MemToRegM = 0; IsLbSbM = 0; IsLhShM = 0; IsUnsignedM = 0;
    ALUOutM = 0; WriteDataM = 0;
  endtask

  // Drive one access, compare outputs mid-cycle, then let the edge commit.
  task automatic apply(input vec_t v);
    exp_t e;
    ALUOutM = v.addr; WriteDataM = v.wdata; MemWriteM = v.we; MemToRegM = v.re;
    IsLbSbM = v.lb; IsLhShM = v.lh; IsUnsignedM = v.uns;
    e.rd = v.exp_rd; e.err = v.exp_err;
    sbq.push_back(e);
    @(negedge clk);
    e = sbq.pop_front();
    chk({v.name, ".rd"}, ReadDataM, e.rd);
    chk({v.name, ".err"}, {31'd0, AlignErrM}, {31'd0, e.err});
    chk({v.name, ".stcnt"}, StoreCount, mdl_st);
    chk({v.name, ".ldcnt"}, LoadCount, mdl_ld);
    chk({v.name, ".sticky"}, {31'd0, AlignErrSticky}, {31'd0, mdl_sticky});
    if (v.we && !v.exp_err) mdl_st = mdl_st + 1;
    else if (v.re && !v.exp_err) mdl_ld = mdl_ld + 1;
    if (v.exp_err) mdl_sticky = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             name      addr          wdata         we re lb lh u  exp_rd        err
    tbl[0]  = mk("sw_dead",  32'h10,       32'hDEADBEEF, 1, 0, 0, 0, 0, 32'h0,        0);
    tbl[1]  = mk("lw_dead",  32'h10,       32'h0,        0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
    tbl[2]  = mk("sw_1122",  32'h10,       32'h11223344, 1, 0, 0, 0, 0, 32'h0,        0);
    tbl[3]  = mk("sb_80",    32'h13,       32'hFFFFFF80, 1, 0, 1, 0, 0, 32'h0,        0);
    tbl[4]  = mk("lw_sb",    32'h10,       32'h0,        0, 1, 0, 0, 0, 32'h80223344, 0);
    tbl[5]  = mk("lb_13",    32'h13,       32'h0,        0, 1, 1, 0, 0, 32'hFFFFFF80, 0);
    tbl[6]  = mk("lbu_13",   32'h13,       32'h0,        0, 1, 1, 0, 1, 32'h00000080, 0);
    tbl[7]  = mk("sw_zero",  32'h10,       32'h0,        1, 0, 0, 0, 0, 32'h0,        0);
    tbl[8]  = mk("sh_8001",  32'h12,       32'h12348001, 1, 0, 0, 1, 0, 32'h0,        0);
    tbl[9]  = mk("lh_12",    32'h12,       32'h0,        0, 1, 0, 1, 0, 32'hFFFF8001, 0);
    tbl[10] = mk("lhu_12",   32'h12,       32'h0,        0, 1, 0, 1, 1, 32'h00008001, 0);
    tbl[11] = mk("lw_sh",    32'h10,       32'h0,        0, 1, 0, 0, 0, 32'h80010000, 0);
    tbl[12] = mk("sw_5555",  32'h20,       32'h55555555, 1, 0, 0, 0, 0, 32'h0,        0);
    tbl[13] = mk("sw_mis",   32'h21,       32'hFFFFFFFF, 1, 0, 0, 0, 0, 32'h0,        1);
    tbl[14] = mk("lh_mis",   32'h23,       32'h0,        0, 1, 0, 1, 0, 32'h0,        1);
    tbl[15] = mk("lw_unch",  32'h20,       32'h0,        0, 1, 0, 0, 0, 32'h55555555, 0);
    tbl[16] = mk("sw_alias", 32'h1004,     32'hA5A5A5A5, 1, 0, 0, 0, 0, 32'h0,        0);
    tbl[17] = mk("lw_alias", 32'h0004,     32'h0,        0, 1, 0, 0, 0, 32'hA5A5A5A5, 0);
    tbl[18] = mk("lb_odd",   32'h21,       32'h0,        0, 1, 1, 0, 0, 32'h00000055, 0);
    tbl[19] = mk("lh_hi",    32'h22,       32'h0,        0, 1, 0, 1, 0, 32'h00005555, 0);
    tbl[20] = mk("both",     32'h20,       32'h0BADF00D, 1, 1, 0, 0, 0, 32'h55555555, 0);
    tbl[21] = mk("lw_both",  32'h20,       32'h0,        0, 1, 0, 0, 0, 32'h0BADF00D, 0);
    tbl[22] = mk("bubble",   32'h21,       32'h0,        0, 0, 0, 0, 0, 32'h0,        0);
    tbl[23] = mk("sh_hi",    32'h16,       32'hFFFFC3A7, 1, 0, 0, 1, 0, 32'h0,        0);

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and an aligned load from cleared memory.
    apply(mk("rst_lw", 32'h10, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0));

    for (int i = 0; i < 24; i++) apply(tbl[i]);
    apply(mk("lw_shhi", 32'h14, 32'h0, 0, 1, 0, 0, 0, 32'hC3A70000, 0));

    // Store coincident with reset is dropped; memory and counters cleared.
    ALUOutM = 32'h40; WriteDataM = 32'h12345678; MemWriteM = 1; MemToRegM = 0;
    IsLbSbM = 0; IsLhShM = 0; IsUnsignedM = 0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    mdl_st = 0; mdl_ld = 0; mdl_sticky = 0;
    apply(mk("rst_st", 32'h40, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0));
    apply(mk("rst_clr", 32'h20, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0));

    // StoreCount wrap: preload to all-ones, one more store rolls to zero.
    force dut.store_cnt = 32'hFFFFFFFF;
    #1 release dut.store_cnt;
    mdl_st = 32'hFFFFFFFF;
    apply(mk("sw_wrap", 32'h40, 32'h77, 1, 0, 0, 0, 0, 32'h0, 0));
    apply(mk("lw_wrap", 32'h40, 32'h0, 0, 1, 0, 0, 0, 32'h77, 0));
    chk("wrap_zero", StoreCount, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

MEM-stage data memory unit for the 5-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes that register's M-stage outputs. It performs byte-, halfword- and word-granular stores into a word-organised data RAM and returns sign- or zero-extended load data to the MEM/WB register. It also flags misaligned accesses and keeps load/store event counters for debug.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ALUOutM  in  32  byte address of the access.
- WriteDataM  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- MemWriteM  in  1  store request this cycle.
- MemToRegM  in  1  load request this cycle.
- IsLbSbM  in  1  byte-sized access.
- IsLhShM  in  1  halfword-sized access; word when neither size flag is set.
- IsUnsignedM  in  1  zero-extend load (lbu/lhu); sign-extend when 0.
- ReadDataM  out  32  extended load data (combinational).
- AlignErrM  out  1  current access misaligned (combinational).
- AlignErrSticky  out  1  registered; set by any misaligned access.
- LoadCount  out  32  registered count of performed loads.
- StoreCount  out  32  registered count of performed stores.

## Operation
- Word index = ALUOutM[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo 2^(ADDR_WIDTH+2).
- Byte offset off = ALUOutM[1:0]. Lanes are little-endian: off=0 selects bits [7:0], off=3 selects [31:24].
- Size precedence: IsLbSbM over IsLhShM over word.
- Misaligned conditions:
  - halfword with off[0]=1;
  - word with off≠0;
  - byte accesses are never misaligned.
  - AlignErrM = (MemWriteM|MemToRegM) & misaligned.
- Store, when MemWriteM=1 and not misaligned:
  - byte: write WriteDataM[7:0] into lane off only.
  - half: write WriteDataM[15:0] into lanes {off[1],0} and {off[1],1} only.
  - word: write all four lanes.
  - Unselected lanes keep their contents.
  - A misaligned store writes nothing.
- Load, when MemToRegM=1 and not misaligned:
  - Select the byte or half at off from the RAM word.
  - IsUnsignedM=1: zero-extend. IsUnsignedM=0: replicate bit 7 (byte) or bit 15 (half).
  - Word loads pass through unchanged.
- ReadDataM = 0 when MemToRegM=0 or the load is misaligned.
- Counters, each incrementing by 1 per cycle:
  - StoreCount on a performed (aligned) store.
  - LoadCount on a performed (aligned) load.
  - Both wrap from 0xFFFFFFFF to 0.
- MemWriteM and MemToRegM both set in the same cycle (illegal from decode):
  - The access is treated as a store.
  - ReadDataM still shows pre-write RAM contents.
  - Only StoreCount increments.
  - The alignment check uses the common size.
- AlignErrSticky sets on the edge after any cycle with AlignErrM=1. It clears only on rst.

## Timing
- Reads are combinational from the array in the same cycle; zero-cycle latency into the MEM/WB register.
- Writes commit on the rising edge at the end of the MEM cycle.
- A load to the same word in the next cycle returns the new data.
- A load in the same cycle as a store returns the old data.
- Reset, applied on the clk edge with rst=1:
  - All RAM words become 0.
  - LoadCount=0, StoreCount=0, AlignErrSticky=0.
  - Combinational outputs then follow the inputs: ReadDataM=0 for any aligned load.
- rst has priority over a coincident store: the store is dropped and memory is cleared.
- No stall or handshake. Every cycle is one access; the upstream register supplies a bubble (all control 0) when needed.

## Test plan
- Reset, then word store 0xDEADBEEF @0x10, then word load @0x10:
  - ReadDataM=0xDEADBEEF, StoreCount=1, LoadCount=1.
- sb 0x80 @0x13 over word 0x11223344:
  - lw @0x10 → 0x80223344.
  - lb @0x13 → 0xFFFFFF80.
  - lbu @0x13 → 0x00000080.
- sh 0x8001 @0x12 over 0x00000000:
  - lh @0x12 → 0xFFFF8001.
  - lhu → 0x00008001.
  - lw @0x10 → 0x80010000.
- sw @0x21 and lh @0x23:
  - AlignErrM=1 in both cycles.
  - Memory unchanged, ReadDataM=0.
  - Counters unchanged, AlignErrSticky=1 from the next cycle.
- Aliasing (ADDR_WIDTH=10): sw 0xA5A5A5A5 @0x1004, then lw @0x0004 → 0xA5A5A5A5.
- Store with rst=1 on the same edge: memory stays 0, StoreCount=0. Preload StoreCount near wrap (0xFFFFFFFF store events) → next store gives 0.
